// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-port memory between instruction fetch and load/store.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    // instruction-fetch port
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,
    // load/store port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,
    // memory port
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    // status
    output logic            grant_d,
    output logic            bus_err
);

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [SW-1:0]   r_mem_wstrb;
    logic [DW-1:0]   r_if_rdata;
    logic            r_if_ack;
    logic [DW-1:0]   r_d_rdata;
    logic            r_d_ack;
    logic            r_grant_d;

`ifdef ARB_TIMEOUT_EN
    localparam int            CW      = 16;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0]   r_cnt;
    logic            r_bus_err;
`endif

    logic w_any_req;
    logic w_pick_d;

    // On a tie the data port wins only if fetch owned the last transaction.
    assign w_any_req = if_req | d_req;
    assign w_pick_d  = d_req & (~if_req | ~r_grant_d);

    // NOTE: every state register below uses non-blocking assignments so all
    // fields update together at the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_if_rdata  <= '0;
            r_if_ack    <= 1'b0;
            r_d_rdata   <= '0;
            r_d_ack     <= 1'b0;
            r_grant_d   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_bus_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state   <= S_BUSY;
                        r_mem_req <= 1'b1;
                        r_grant_d <= w_pick_d;
`ifdef ARB_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                        if (w_pick_d) begin
                            r_mem_addr  <= d_addr;
                            r_mem_we    <= d_we;
                            r_mem_wdata <= d_wdata;
                            r_mem_wstrb <= d_wstrb;
                        end else begin
                            r_mem_addr  <= if_addr;
                            r_mem_we    <= 1'b0;
                            r_mem_wdata <= '0;
                            r_mem_wstrb <= '0;
                        end
                    end
                end

                S_BUSY: begin
                    if (mem_ack) begin
                        r_state   <= S_RESP;
                        r_mem_req <= 1'b0;
                        if (r_grant_d) begin
                            r_d_ack   <= 1'b1;
                            r_d_rdata <= r_mem_we ? '0 : mem_rdata;
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= mem_rdata;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        r_state   <= S_RESP;
                        r_mem_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (r_grant_d) begin
                            r_d_ack   <= 1'b1;
                            r_d_rdata <= '0;
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
`endif
                end

                S_RESP: begin
                    r_state  <= S_IDLE;
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    r_bus_err <= 1'b0;
`endif
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign if_rdata  = r_if_rdata;
    assign if_ack    = r_if_ack;
    assign d_rdata   = r_d_rdata;
    assign d_ack     = r_d_ack;
    assign grant_d   = r_grant_d;

`ifdef ARB_TIMEOUT_EN
    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

    // Structural invariants of the handshake.
    a_timeout_cfg: assert property (@(posedge clk) TIMEOUT_CYCLES >= 1);
    a_one_ack:     assert property (@(posedge clk) disable iff (rst) !(r_if_ack && r_d_ack));
    a_busy_req:    assert property (@(posedge clk) disable iff (rst) (r_state == S_BUSY) |-> r_mem_req);
    a_ack_in_resp: assert property (@(posedge clk) disable iff (rst) (r_if_ack || r_d_ack) |-> (r_state == S_RESP));

endmodule
